// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//
// Purpose:
//    Hazard unit for a classic five-stage MIPS-style pipeline. It keeps its
//    own shadow copy of the E, M and W stage control fields and uses them to
//    produce stall, flush and forwarding controls for the datapath.
//
// Optional feature:
//    Define HAZARD_PERF_CNT_EN to build saturating stall/flush performance
//    counters. Without it, both counter ports read 0 and no counter flops
//    exist.
//
// Ports:
//    CLK                    clock, rising edge
//    RST                    asynchronous active-low reset
//    ValidD                 Decode holds a real instruction
//    RegWriteD              Decode instruction writes the register file
//    MemtoRegD              Decode instruction is a load
//    BranchD                Decode instruction is a branch resolved in Decode
//    RsD, RtD               Decode source registers
//    WriteRegD              Decode destination (after the RegDst mux)
//    StallF, StallD         hold Fetch and Fetch/Decode registers
//    FlushE                 clear of the Decode-to-Execute register
//    ForwardAE, ForwardBE   Execute operand select: 00 RF, 01 W, 10 M
//    ForwardAD, ForwardBD   Decode comparator operand from Memory
//    StallCount, FlushCount performance counters
// ---------------------------------------------------------------------------
module hazard_controller #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      ValidD,
   input  logic                      RegWriteD,
   input  logic                      MemtoRegD,
   input  logic                      BranchD,
   input  logic [REG_ADDR_WIDTH-1:0] RsD,
   input  logic [REG_ADDR_WIDTH-1:0] RtD,
   input  logic [REG_ADDR_WIDTH-1:0] WriteRegD,
   output logic                      StallF,
   output logic                      StallD,
   output logic                      FlushE,
   output logic [1:0]                ForwardAE,
   output logic [1:0]                ForwardBE,
   output logic                      ForwardAD,
   output logic                      ForwardBD,
   output logic [CNT_WIDTH-1:0]      StallCount,
   output logic [CNT_WIDTH-1:0]      FlushCount
);

   // Shadow E stage: the only stage that needs its source registers.
   logic                      r_eValid;
   logic                      r_eRegWrite;
   logic                      r_eMemtoReg;
   logic [REG_ADDR_WIDTH-1:0] r_eWriteReg;
   logic [REG_ADDR_WIDTH-1:0] r_eRs;
   logic [REG_ADDR_WIDTH-1:0] r_eRt;

   // Shadow M stage.
   logic                      r_mValid;
   logic                      r_mRegWrite;
   logic                      r_mMemtoReg;
   logic [REG_ADDR_WIDTH-1:0] r_mWriteReg;

   // Shadow W stage. Its MemtoReg bit has no consumer once the value is in
   // Writeback (the forward source is the same either way), so it is not kept.
   logic                      r_wValid;
   logic                      r_wRegWrite;
   logic [REG_ADDR_WIDTH-1:0] r_wWriteReg;

   logic w_eWritesRsD, w_eWritesRtD;
   logic w_mWritesRsD, w_mWritesRtD;
   logic w_mWritesERs, w_mWritesERt;
   logic w_wWritesERs, w_wWritesERt;
   logic w_lwStall, w_branchStall, w_stall;

   // A stage produces register r only when it is a real, register-writing
   // instruction with a non-zero destination; r0 never forwards or stalls.
   function automatic logic writesReg(
      input logic                      valid,
      input logic                      regWrite,
      input logic [REG_ADDR_WIDTH-1:0] writeReg,
      input logic [REG_ADDR_WIDTH-1:0] r
   );
      return valid & regWrite & (writeReg == r) & (r != '0);
   endfunction

   assign w_eWritesRsD = writesReg(r_eValid, r_eRegWrite, r_eWriteReg, RsD);
   assign w_eWritesRtD = writesReg(r_eValid, r_eRegWrite, r_eWriteReg, RtD);
   assign w_mWritesRsD = writesReg(r_mValid, r_mRegWrite, r_mWriteReg, RsD);
   assign w_mWritesRtD = writesReg(r_mValid, r_mRegWrite, r_mWriteReg, RtD);
   assign w_mWritesERs = writesReg(r_mValid, r_mRegWrite, r_mWriteReg, r_eRs);
   assign w_mWritesERt = writesReg(r_mValid, r_mRegWrite, r_mWriteReg, r_eRt);
   assign w_wWritesERs = writesReg(r_wValid, r_wRegWrite, r_wWriteReg, r_eRs);
   assign w_wWritesERt = writesReg(r_wValid, r_wRegWrite, r_wWriteReg, r_eRt);

   // A load in E cannot forward to a dependent instruction in Decode yet.
   assign w_lwStall = r_eMemtoReg & (w_eWritesRsD | w_eWritesRtD);

   // The Decode comparator can only take a value from M, and only if it is an
   // ALU result; anything still in E, or a load in M, must wait.
   assign w_branchStall = BranchD &
                          ((w_eWritesRsD | w_eWritesRtD) |
                           (r_mMemtoReg & (w_mWritesRsD | w_mWritesRtD)));

   // Both stall causes collapse into one stall; gating with RST drops a stall
   // the moment reset is asserted, independent of the shadow clear.
   assign w_stall = RST & ValidD & (w_lwStall | w_branchStall);

   assign StallF = w_stall;
   assign StallD = w_stall;
   assign FlushE = w_stall;

   // Memory is the younger producer, so it wins over Writeback.
   assign ForwardAE = w_mWritesERs ? 2'b10 : (w_wWritesERs ? 2'b01 : 2'b00);
   assign ForwardBE = w_mWritesERt ? 2'b10 : (w_wWritesERt ? 2'b01 : 2'b00);

   // The register file writes in the first half-cycle, so Writeback never
   // needs a path to Decode.
   assign ForwardAD = w_mWritesRsD;
   assign ForwardBD = w_mWritesRtD;

   // Shadow pipeline. E mirrors the Decode-to-Execute register: it clears on
   // the same FlushE and reset, and takes a bubble when Decode is empty.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_eValid    <= 1'b0;
         r_eRegWrite <= 1'b0;
         r_eMemtoReg <= 1'b0;
         r_eWriteReg <= '0;
         r_eRs       <= '0;
         r_eRt       <= '0;
         r_mValid    <= 1'b0;
         r_mRegWrite <= 1'b0;
         r_mMemtoReg <= 1'b0;
         r_mWriteReg <= '0;
         r_wValid    <= 1'b0;
         r_wRegWrite <= 1'b0;
         r_wWriteReg <= '0;
      end else begin
         r_wValid    <= r_mValid;
         r_wRegWrite <= r_mRegWrite;
         r_wWriteReg <= r_mWriteReg;
         r_mValid    <= r_eValid;
         r_mRegWrite <= r_eRegWrite;
         r_mMemtoReg <= r_eMemtoReg;
         r_mWriteReg <= r_eWriteReg;
         if (w_stall) begin
            r_eValid    <= 1'b0;
            r_eRegWrite <= 1'b0;
            r_eMemtoReg <= 1'b0;
            r_eWriteReg <= '0;
            r_eRs       <= '0;
            r_eRt       <= '0;
         end else begin
            r_eValid    <= ValidD;
            r_eRegWrite <= RegWriteD;
            r_eMemtoReg <= MemtoRegD;
            r_eWriteReg <= WriteRegD;
            r_eRs       <= RsD;
            r_eRt       <= RtD;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] r_stallCount;
   logic [CNT_WIDTH-1:0] r_flushCount;

   // Saturating counters: once all-ones they hold rather than wrap.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_stallCount <= '0;
         r_flushCount <= '0;
      end else begin
         if (w_stall && (r_stallCount != '1)) begin
            r_stallCount <= r_stallCount + CNT_ONE;
         end
         if (w_stall && (r_flushCount != '1)) begin
            r_flushCount <= r_flushCount + CNT_ONE;
         end
      end
   end

   assign StallCount = r_stallCount;
   assign FlushCount = r_flushCount;
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule
